// File: rtl/wb_arbiter_pkg.sv
// Shared processor constants and writeback-arbiter state encoding.
package wb_arbiter_pkg;

  localparam int unsigned PROC_ARCH_BITS    = 32;
  localparam int unsigned PROC_REG_IDX_BITS = 5;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered MEM results; head is visible only from the
// edge after the push (no write-through bypass).
module wb_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered MEM
// results into the register file write port, with a starvation drain mode.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ARCH_BITS    = PROC_ARCH_BITS,
  parameter int unsigned REG_IDX_BITS = PROC_REG_IDX_BITS,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [REG_IDX_BITS-1:0]    alu_dst,
  input  logic                       alu_special,
  input  logic [ARCH_BITS-1:0]       alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [REG_IDX_BITS-1:0]    mem_dst,
  input  logic                       mem_special,
  input  logic [ARCH_BITS-1:0]       mem_data,
  output logic                       alu_stall,
  output logic [REG_IDX_BITS-1:0]    dst,
  output logic                       specialDst,
  output logic [ARCH_BITS-1:0]       wData,
  output logic                       writeEnable,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CNT_BITS    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STARVE_BITS = $clog2(STARVE_LIMIT) + 1;
  localparam int unsigned ENTRY_BITS  = 1 + REG_IDX_BITS + ARCH_BITS;

  localparam logic [CNT_BITS-1:0]    DEPTH_CNT  = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0]    HALF_CNT   = CNT_BITS'(FIFO_DEPTH / 2);
  localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic                    special;
    logic [REG_IDX_BITS-1:0] dst;
    logic [ARCH_BITS-1:0]    data;
  } wb_entry_t;

  wb_state_e                state;
  logic [STARVE_BITS-1:0]   starve_cnt;
  wb_entry_t                push_entry;
  wb_entry_t                head;
  logic [ENTRY_BITS-1:0]    head_bits;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     starving;
  logic [CNT_BITS-1:0]      count_next;

  assign mem_ready  = (fifo_count < DEPTH_CNT);
  assign push       = mem_valid && mem_ready;
  assign push_entry = '{special: mem_special, dst: mem_dst, data: mem_data};
  assign head       = wb_entry_t'(head_bits);

  // ALU has priority in NORMAL; in DRAIN the FIFO owns the port outright.
  assign pop      = !fifo_empty && ((state == DRAIN) || !alu_valid);
  assign starving = fifo_full && !pop;

  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + 1'b1;
    end else if (!push && pop) begin
      count_next = fifo_count - 1'b1;
    end
  end

  wb_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= NORMAL;
      alu_stall   <= 1'b0;
      starve_cnt  <= '0;
      writeEnable <= 1'b0;
      dst         <= '0;
      specialDst  <= 1'b0;
      wData       <= '0;
    end else begin
      writeEnable <= 1'b0;
      if ((state == NORMAL) && alu_valid) begin
        writeEnable <= 1'b1;
        dst         <= alu_dst;
        specialDst  <= alu_special;
        wData       <= alu_data;
      end else if (pop) begin
        writeEnable <= 1'b1;
        dst         <= head.dst;
        specialDst  <= head.special;
        wData       <= head.data;
      end

      if (starving) begin
        if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end

      // alu_stall is updated alongside state so it mirrors DRAIN from the next cycle.
      case (state)
        NORMAL: begin
          if (starving && (starve_cnt == STARVE_MAX)) begin
            state     <= DRAIN;
            alu_stall <= 1'b1;
          end
        end
        DRAIN: begin
          if (count_next <= HALF_CNT) begin
            state     <= NORMAL;
            alu_stall <= 1'b0;
          end
        end
        default: begin
          state     <= NORMAL;
          alu_stall <= 1'b0;
        end
      endcase
    end
  end

  a_no_alu_in_drain: assert property (@(posedge clk) disable iff (rst) !(alu_valid && (state == DRAIN)));

endmodule
